// File: rtl/w_ptr_handler.sv
// Write-domain pointer and flag logic for an asynchronous FIFO.
// Keeps binary/Gray write pointers, FULL, ALMOST_FULL, fill level and a sticky OVERFLOW.
module w_ptr_handler #(
    parameter int unsigned PTR_WIDTH = 3,
    parameter int unsigned AF_THRESH = 2**PTR_WIDTH - 2
) (
    input  logic                 W_CLK,
    input  logic                 WRST_n,
    input  logic                 W_EN,
    input  logic [PTR_WIDTH:0]   G_RPTR_SYNC,
    input  logic                 OVF_CLR,
    output logic                 W_ACCEPT,
    output logic [PTR_WIDTH:0]   B_WPTR,
    output logic [PTR_WIDTH:0]   G_WPTR,
    output logic                 FULL,
    output logic                 ALMOST_FULL,
    output logic [PTR_WIDTH:0]   WLEVEL,
    output logic                 OVERFLOW
);

    localparam int unsigned AW = PTR_WIDTH + 1;

    logic [AW-1:0] b_wptr_q, b_wptr_d;
    logic [AW-1:0] g_wptr_q, g_wptr_d;
    logic [AW-1:0] wlevel_q, wlevel_d;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic          ovf_q, ovf_d;
    logic          accept_c;
    logic [AW-1:0] rptr_full_c;
    logic [AW-1:0] b_rsync_c;

    // Next-state terms; flags and level already include this edge's accepted write
    always_comb begin
        accept_c    = W_EN & ~full_q;
        b_wptr_d    = b_wptr_q + AW'(accept_c);
        g_wptr_d    = (b_wptr_d >> 1) ^ b_wptr_d;
        // Read pointer with the two MSBs flipped: equal Gray codes mean DEPTH apart
        rptr_full_c = G_RPTR_SYNC ^ (AW'(3) << (PTR_WIDTH - 1));
        full_d      = (g_wptr_d == rptr_full_c);
        b_rsync_c   = '0;
        for (int i = 0; i < int'(AW); i++) begin
            b_rsync_c[i] = ^(G_RPTR_SYNC >> i);
        end
        wlevel_d    = b_wptr_d - b_rsync_c;
        afull_d     = (32'(wlevel_d) >= AF_THRESH);
        ovf_d       = (W_EN & full_q) | (ovf_q & ~OVF_CLR);
    end

    // State registers
    always_ff @(posedge W_CLK or negedge WRST_n) begin
        if (!WRST_n) begin
            b_wptr_q <= '0;
            g_wptr_q <= '0;
            wlevel_q <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            b_wptr_q <= b_wptr_d;
            g_wptr_q <= g_wptr_d;
            wlevel_q <= wlevel_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
        end
    end

    assign W_ACCEPT    = accept_c;
    assign B_WPTR      = b_wptr_q;
    assign G_WPTR      = g_wptr_q;
    assign FULL        = full_q;
    assign ALMOST_FULL = afull_q;
    assign WLEVEL      = wlevel_q;
    assign OVERFLOW    = ovf_q;

endmodule

// File: tb/tb_w_ptr_handler.sv
// Directed bench for w_ptr_handler (PTR_WIDTH=3, AF_THRESH=6) with a count-based reference model.
module tb_w_ptr_handler;

    logic       W_CLK = 1'b0;
    logic       WRST_n;
    logic       W_EN;
    logic [3:0] G_RPTR_SYNC;
    logic       OVF_CLR;
    logic       W_ACCEPT;
    logic [3:0] B_WPTR;
    logic [3:0] G_WPTR;
    logic       FULL;
    logic       ALMOST_FULL;
    logic [3:0] WLEVEL;
    logic       OVERFLOW;

    int total = 0;
    int bad   = 0;

    w_ptr_handler #(.PTR_WIDTH(3), .AF_THRESH(6)) dut (
        .W_CLK(W_CLK), .WRST_n(WRST_n), .W_EN(W_EN), .G_RPTR_SYNC(G_RPTR_SYNC),
        .OVF_CLR(OVF_CLR), .W_ACCEPT(W_ACCEPT), .B_WPTR(B_WPTR), .G_WPTR(G_WPTR),
        .FULL(FULL), .ALMOST_FULL(ALMOST_FULL), .WLEVEL(WLEVEL), .OVERFLOW(OVERFLOW)
    );

    always #5 W_CLK = ~W_CLK;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int gray(input int v);
        return (v ^ (v >> 1)) & 15;
    endfunction

    // Gray decode by search over the code table
    function automatic int g2b(input logic [3:0] g);
        for (int v = 0; v < 16; v++) if (gray(v) == int'(g)) return v;
        return 0;
    endfunction

    // Reference model: total accepted writes and occupancy as plain integers
    int m_w = 0, m_lvl = 0;
    bit m_full = 0, m_af = 0, m_ovf = 0;

    always @(posedge W_CLK or negedge WRST_n) begin
        if (!WRST_n) begin
            m_w = 0; m_lvl = 0; m_full = 0; m_af = 0; m_ovf = 0;
        end else begin
            m_ovf  = (W_EN && m_full) || (m_ovf && !OVF_CLR);
            m_w    = (m_w + ((W_EN && !m_full) ? 1 : 0)) % 16;
            m_lvl  = (m_w - g2b(G_RPTR_SYNC) + 16) % 16;
            m_full = (m_lvl == 8);
            m_af   = (m_lvl >= 6);
        end
    end

    bit chk_on = 0;
    logic [3:0] prev_g = '0;

    // Per-cycle comparison against the model, plus one-Gray-step check
    always @(posedge W_CLK) begin
        #2;
        if (chk_on) begin
            check("accept", int'(W_ACCEPT), int'(W_EN && !m_full));
            check("b_wptr", int'(B_WPTR), m_w);
            check("g_wptr", int'(G_WPTR), gray(m_w));
            check("full", int'(FULL), int'(m_full));
            check("almost_full", int'(ALMOST_FULL), int'(m_af));
            check("wlevel", int'(WLEVEL), m_lvl);
            check("overflow", int'(OVERFLOW), int'(m_ovf));
            if (G_WPTR != prev_g && WRST_n)
                check("gray_onebit", $countones(G_WPTR ^ prev_g), 1);
        end
        prev_g = G_WPTR;
    end

    task automatic step();
        @(posedge W_CLK);
        #1;
    endtask

    initial begin
        int  p;
        bit  saw_b_wrap, saw_g_wrap;
        logic [3:0] pb, pg;

        WRST_n = 1'b0; W_EN = 1'b1; G_RPTR_SYNC = '0; OVF_CLR = 1'b0;
        step(); step();
        chk_on = 1;
        check("rst_b", int'(B_WPTR), 0);
        check("rst_g", int'(G_WPTR), 0);
        check("rst_full", int'(FULL), 0);
        check("rst_lvl", int'(WLEVEL), 0);
        check("rst_ovf", int'(OVERFLOW), 0);
        check("rst_af", int'(ALMOST_FULL), 0);

        WRST_n = 1'b1;
        #0 check("accept_after_rst", int'(W_ACCEPT), 1);

        // Fill from empty with read pointer at 0
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 5) check("af_before6", int'(ALMOST_FULL), 0);
            if (k == 6) begin
                check("af_at6", int'(ALMOST_FULL), 1);
                check("lvl_at6", int'(WLEVEL), 6);
            end
        end
        check("fill_b", int'(B_WPTR), 8);
        check("fill_g", int'(G_WPTR), 12);
        check("fill_full", int'(FULL), 1);
        check("fill_lvl", int'(WLEVEL), 8);

        // Overflow set, set-wins, then clear
        check("ovf_accept", int'(W_ACCEPT), 0);
        step();
        check("ovf_b_hold", int'(B_WPTR), 8);
        check("ovf_set", int'(OVERFLOW), 1);
        OVF_CLR = 1'b1;
        step();
        check("ovf_set_wins", int'(OVERFLOW), 1);
        W_EN = 1'b0;
        step();
        check("ovf_clr", int'(OVERFLOW), 0);
        OVF_CLR = 1'b0;

        // Drain while full
        G_RPTR_SYNC = 4'b0011;
        step();
        check("drain_full", int'(FULL), 0);
        check("drain_lvl6", int'(WLEVEL), 6);
        check("drain_af1", int'(ALMOST_FULL), 1);
        G_RPTR_SYNC = 4'b0101;
        step();
        check("drain_lvl2", int'(WLEVEL), 2);
        check("drain_af0", int'(ALMOST_FULL), 0);

        // Wrap: 20 writes with the read pointer trailing by 2
        p = 8; saw_b_wrap = 0; saw_g_wrap = 0;
        W_EN = 1'b1;
        for (int k = 0; k < 20; k++) begin
            pb = B_WPTR; pg = G_WPTR;
            step();
            p = (p + 1) % 16;
            check("wrap_nofull", int'(FULL), 0);
            if (pb == 4'b1111 && B_WPTR == 4'b0000) saw_b_wrap = 1;
            if (pg == 4'b1000 && G_WPTR == 4'b0000) saw_g_wrap = 1;
            G_RPTR_SYNC = 4'(gray((p + 14) % 16));
        end
        check("wrap_b_seen", int'(saw_b_wrap), 1);
        check("wrap_g_seen", int'(saw_g_wrap), 1);
        check("wrap_b_end", int'(B_WPTR), 12);

        // Async reset mid-fill at level 5
        G_RPTR_SYNC = 4'(gray(p));
        for (int k = 0; k < 5; k++) step();
        check("mid_lvl5", int'(WLEVEL), 5);
        #2 WRST_n = 1'b0;
        #1;
        check("async_b", int'(B_WPTR), 0);
        check("async_g", int'(G_WPTR), 0);
        check("async_lvl", int'(WLEVEL), 0);
        check("async_full", int'(FULL), 0);
        check("async_af", int'(ALMOST_FULL), 0);
        check("async_ovf", int'(OVERFLOW), 0);
        step();
        WRST_n = 1'b1; W_EN = 1'b0; G_RPTR_SYNC = '0;
        step(); step();
        chk_on = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
